mat_result_serializer: RTL and testbench
========================================

Name: mat_result_serializer

Overview:
Downstream neighbour of the matrix-multiply stage. Captures each full N×N result matrix when the multiplier's valid pulse fires, holding up to two matrices in a ping-pong buffer. Streams the buffered matrices one W_OUT element per beat over a valid/ready interface to the writeback/output path. The multiplier has no backpressure, so a third matrix arriving while the buffer is full is dropped and flagged.

Parameters:
W_OUT, 32, width of one result element (signed)
N, 4, matrix dimension; a matrix holds N*N elements
IDX_W, $clog2(N*N), width of the element index output

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  one clock; reset is asynchronous and active-high
valid_in  input  1  single-cycle pulse: result_in holds a complete matrix
result_in  input  N*N*W_OUT  packed matrix; element k = result_in[k*W_OUT +: W_OUT], k = r*N+c
ovf_clr  input  1  clears the sticky overflow flag
m_ready  input  1  downstream accepts the current beat
m_valid  output  1  beat valid
m_data  output  W_OUT  current element
m_index  output  IDX_W  index k of the element on m_data
m_last  output  1  high on the final beat of a matrix (k = N*N-1)
can_accept  output  1  buffer count < 2 (informational only; upstream does not stall)
overflow  output  1  sticky: a matrix was dropped

Behaviour:
- Storage: two matrix slots, write pointer wp, read pointer rp, count 0..2, element counter idx 0..N*N-1.
- Reset (async assert, sync-safe release): slots zeroed; wp=rp=0; count=0; idx=0; overflow=0. All outputs read 0.
- States: EMPTY (count=0), STREAM (count>=1). m_valid = (count != 0).
- Capture: valid_in with count<2 writes result_in into slot[wp]; wp toggles; count increments.
- Latency: valid_in at cycle t into an empty buffer gives m_valid=1 with element 0 at cycle t+1.
- Output: m_data = element idx of slot[rp]. m_index = idx. m_last = m_valid && idx == N*N-1. Outputs are driven only from registers and a mux.
- Beat transfer: occurs on a cycle with m_valid && m_ready.
  - If idx < N*N-1: idx increments.
  - If idx = N*N-1: idx returns to 0, rp toggles, count decrements.
- Hold rule: while m_valid && !m_ready, m_data, m_index and m_last are stable. The slot at rp is never overwritten while it is being read.
- Simultaneous capture and last-beat drain: capture is accepted even when count=2. count is unchanged net; the new matrix goes to the slot just freed (wp equals the old rp).
- Overflow: valid_in with count=2 and no simultaneous last-beat drain drops the matrix and sets overflow. Buffer contents, pointers and the stream are untouched.
- ovf_clr clears overflow. If ovf_clr and a new drop occur in the same cycle, set wins.
- m_ready is ignored when m_valid=0. valid_in is sampled every cycle, including back-to-back cycles.
- Reset mid-stream: all in-flight and buffered data is discarded; the stream restarts cleanly after release.
- Elements are passed through bit-exact; no arithmetic is applied.

Optional Feature:
Macro: MAT_SER_COLMAJOR_EN
- Defined: beats are emitted column-major. Beat j outputs element k = (j mod N)*N + (j div N), and m_index reports that k. m_last remains on beat j = N*N-1 (k = N*N-1).
- Undefined: beats are emitted row-major, k = j.
- Handshake, buffering and overflow behaviour are identical in both builds.

Test Plan:
- Single matrix, m_ready held 1. Pulse valid_in with element k = k+100 (N=4) -> from the next cycle, 16 consecutive beats carry m_data 100..115 and m_index 0..15; m_last only on beat 15; m_valid falls the cycle after.
- Backpressure: toggle m_ready 1,0,0,1 repeatedly -> no beat is duplicated or skipped; m_data and m_index stay stable across the stalled cycles; all 16 elements arrive in order.
- Two back-to-back valid_in pulses (matrix A, then B = A+1000) with m_ready=0 -> can_accept=0 and overflow=0. Releasing m_ready streams all of A, then all of B, with no gap between them.
- Third valid_in while full, m_ready=0 -> overflow=1; streamed output is A then B only. Assert ovf_clr -> overflow=0.
- Buffer full, valid_in asserted in the same cycle as A's last beat with m_ready=1 -> C is accepted, overflow stays 0, and the output sequence is A, B, C.
- Assert reset at beat 7 of A with B buffered -> next cycle m_valid=0, overflow=0, can_accept=1. A fresh valid_in after reset is released streams from m_index 0.
- With MAT_SER_COLMAJOR_EN defined, repeat the first scenario -> beat order is m_index 0,4,8,12,1,5,… ending at 15 with m_last=1.

Source files
------------

// File: rtl/mat_result_serializer.sv
// Ping-pong result buffer that streams N*N matrices one element per beat.
// Optional MAT_SER_COLMAJOR_EN: emit elements in column-major beat order.
module mat_result_serializer #(
  parameter int W_OUT = 32,
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N*N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  input  logic [N*N*W_OUT-1:0]   result_in,
  input  logic                   ovf_clr,
  input  logic                   m_ready,
  output logic                   m_valid,
  output logic [W_OUT-1:0]       m_data,
  output logic [IDX_W-1:0]       m_index,
  output logic                   m_last,
  output logic                   can_accept,
  output logic                   overflow
);

  localparam int NN = N * N;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NN - 1);

  typedef enum logic {EMPTY, STREAM} state_t;

  state_t               state_q;
  logic [NN*W_OUT-1:0]  slot0_q, slot1_q;
  logic                 wp_q, rp_q;
  logic [1:0]           count_q, count_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 ovf_q;

  logic                 beat, drain, cap, drop;
  logic [IDX_W-1:0]     k;
  logic [NN*W_OUT-1:0]  rd_slot;

  // Beat/capture decisions; a last-beat drain frees a slot for a same-cycle capture.
  always_comb begin
    beat    = m_valid && m_ready;
    drain   = beat && (idx_q == LAST);
    cap     = valid_in && ((count_q < 2'd2) || drain);
    drop    = valid_in && (count_q == 2'd2) && !drain;
    count_d = count_q + {1'b0, cap} - {1'b0, drain};
    idx_d   = idx_q;
    if (beat) idx_d = drain ? '0 : idx_q + IDX_W'(1);
  end

  // Beat number to element index mapping.
`ifdef MAT_SER_COLMAJOR_EN
  always_comb k = IDX_W'((int'(idx_q) % N) * N + int'(idx_q) / N);
`else
  always_comb k = idx_q;
`endif

  // Output mux from the slot under read.
  always_comb begin
    rd_slot = rp_q ? slot1_q : slot0_q;
    m_data  = rd_slot[k*W_OUT +: W_OUT];
  end

  assign m_valid    = (state_q == STREAM);
  assign m_index    = k;
  assign m_last     = m_valid && (idx_q == LAST);
  assign can_accept = (count_q < 2'd2);
  assign overflow   = ovf_q;

  // Buffer, pointer, stream and sticky overflow state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      count_q <= 2'd0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (cap && !wp_q) slot0_q <= result_in;
      if (cap && wp_q)  slot1_q <= result_in;
      if (cap)   wp_q <= ~wp_q;
      if (drain) rp_q <= ~rp_q;
      count_q <= count_d;
      idx_q   <= idx_d;
      state_q <= (count_d != 2'd0) ? STREAM : EMPTY;
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mat_result_serializer.sv
// Scoreboard bench for mat_result_serializer.
// Expected beats are queued at capture time and compared as beats transfer.
module tb_mat_result_serializer;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int NN = N * N;
  localparam int IW = 4;

  typedef struct {
    logic [W-1:0]  d;
    logic [IW-1:0] i;
    logic          l;
  } beat_t;

  logic              clk = 0;
  logic              reset;
  logic              valid_in;
  logic [NN*W-1:0]   result_in;
  logic              ovf_clr;
  logic              m_ready;
  logic              m_valid;
  logic [W-1:0]      m_data;
  logic [IW-1:0]     m_index;
  logic              m_last;
  logic              can_accept;
  logic              overflow;

  int n_vec = 0;
  int n_bad = 0;
  beat_t exp_q[$];

  logic          hold_v = 0;
  logic [W-1:0]  hold_d;
  logic [IW-1:0] hold_i;
  logic          hold_l;

  mat_result_serializer #(.W_OUT(W), .N(N), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .result_in(result_in),
    .ovf_clr(ovf_clr), .m_ready(m_ready), .m_valid(m_valid),
    .m_data(m_data), .m_index(m_index), .m_last(m_last),
    .can_accept(can_accept), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int kmap(input int j);
`ifdef MAT_SER_COLMAJOR_EN
    return (j % N) * N + j / N;
`else
    return j;
`endif
  endfunction

  // Called at posedge+1; valid_in is high for exactly one capture edge.
  task automatic send(input int base, input bit push);
    beat_t b;
    for (int k = 0; k < NN; k++) result_in[k*W +: W] = W'(base + k);
    valid_in = 1'b1;
    if (push)
      for (int j = 0; j < NN; j++) begin
        b.d = W'(base + kmap(j));
        b.i = IW'(kmap(j));
        b.l = (j == NN - 1);
        exp_q.push_back(b);
      end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic drain(input int maxc, input bit bp, output int c);
    c = 0;
    while (exp_q.size() != 0 && c < maxc) begin
      m_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      @(posedge clk); #1;
      c++;
    end
    chk("drain_done", 64'(exp_q.size()), 0);
  endtask

  // Compare each transferred beat and check stability across stalls.
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v && m_valid) begin
        chk("hold_data", m_data, hold_d);
        chk("hold_idx", m_index, hold_i);
        chk("hold_last", m_last, hold_l);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("data", m_data, e.d);
          chk("index", m_index, e.i);
          chk("last", m_last, e.l);
        end
      end
      hold_v <= m_valid && !m_ready;
      hold_d <= m_data;
      hold_i <= m_index;
      hold_l <= m_last;
    end
  end

  initial begin
    int c;
    bit found;
    reset = 1; valid_in = 0; result_in = '0; ovf_clr = 0; m_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_index", m_index, 0);
    chk("rst_last", m_last, 0);
    chk("rst_canacc", can_accept, 1);
    chk("rst_ovf", overflow, 0);
    reset = 0;
    @(posedge clk); #1;

    // single matrix, ready held high
    m_ready = 1;
    send(100, 1);
    chk("lat_valid", m_valid, 1);
    chk("lat_index", m_index, 0);
    drain(40, 0, c);
    chk("s1_len", c, 16);
    chk("s1_fall", m_valid, 0);

    // backpressure 1,0,0,1
    m_ready = 0;
    send(700, 1);
    drain(200, 1, c);
    m_ready = 0;
    @(posedge clk); #1;

    // two matrices buffered, then overflow
    send(200, 1);
    send(1200, 1);
    chk("full_canacc", can_accept, 0);
    chk("full_ovf", overflow, 0);
    send(5000, 0);
    chk("drop_ovf", overflow, 1);
    ovf_clr = 1;
    @(posedge clk); #1;
    ovf_clr = 0;
    chk("clr_ovf", overflow, 0);
    ovf_clr = 1;
    send(6000, 0);
    ovf_clr = 0;
    chk("setwins_ovf", overflow, 1);
    ovf_clr = 1;
    @(posedge clk); #1;
    ovf_clr = 0;
    chk("clr2_ovf", overflow, 0);
    drain(100, 0, c);
    chk("ab_nogap", c, 32);
    chk("ab_canacc", can_accept, 1);
    m_ready = 0;

    // capture on the same cycle as A's last beat while full
    send(300, 1);
    send(1300, 1);
    m_ready = 1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_valid && m_last) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("wait_last", found, 1);
    send(2300, 1);
    chk("swap_ovf", overflow, 0);
    drain(100, 0, c);
    chk("abc_ovf", overflow, 0);
    m_ready = 0;

    // reset mid-stream with B buffered and overflow set
    send(400, 1);
    send(1400, 1);
    send(9999, 0);
    chk("pre_rst_ovf", overflow, 1);
    m_ready = 1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_valid && m_index == 4'd7) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("wait_b7", found, 1);
    reset = 1;
    exp_q.delete();
    @(posedge clk); #1;
    chk("mrst_valid", m_valid, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_canacc", can_accept, 1);
    reset = 0;
    @(posedge clk); #1;
    send(600, 1);
    chk("post_rst_idx", m_index, 0);
    chk("post_rst_data", m_data, 600);
    drain(40, 0, c);
    chk("post_rst_len", c, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
